// File: rtl/datapath_seq_if.sv
// Operation handshake, external register-load port and result/status bus of datapath_seq.
// state_dbg mirrors the sequencer state so checkers can bind to it.
interface datapath_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) ();
  localparam int AW = $clog2(NREGS);

  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rn;
  logic [AW-1:0]    rm;
  logic             use_imm;
  logic [WIDTH-1:0] imm;
  logic [1:0]       shift;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Z_out;
  logic             N_out;
  logic             V_out;
  logic             C_out;
  logic [2:0]       state_dbg;

  // start is taken only while busy=0; done pulses for the single cycle after writeback.
  modport master (
    output start, op, rd, rn, rm, use_imm, imm, shift, wr_en, wr_addr, wr_data,
    input  busy, done, result, Z_out, N_out, V_out, C_out, state_dbg
  );

  modport slave (
    input  start, op, rd, rn, rm, use_imm, imm, shift, wr_en, wr_addr, wr_data,
    output busy, done, result, Z_out, N_out, V_out, C_out, state_dbg
  );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B latches, B shifter, ALU with iterative
// shift-add multiplier, result and Z/N/V/C status, driven by a start/busy/done handshake.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  datapath_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_MVN = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [AW-1:0]      rd_q, rn_q, rm_q;
  logic               use_imm_q;
  logic [WIDTH-1:0]   imm_q;
  logic [1:0]         shift_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               z_q, n_q, v_q, c_q, done_q;
  logic [WIDTH-1:0]   regs_q [NREGS];

  logic [WIDTH-1:0]   b_sel, b_shift;
  logic [WIDTH:0]     mul_sum, add_full, sub_full;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_v, alu_c, upd_flags, upd_res, wr_reg;
  logic               accept, mul_last;

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    b_sel = use_imm_q ? imm_q : regs_q[rm_q];
    case (shift_q)
      2'b01:   b_shift = {b_sel[WIDTH-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_sel[WIDTH-1:1]};
      2'b11:   b_shift = {b_sel[WIDTH-1], b_sel[WIDTH-1:1]};
      default: b_shift = b_sel;
    endcase
  end

  // Accumulator holds {partial product, remaining multiplier bits}; A is the multiplicand.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_val   = result_q;
    alu_v     = 1'b0;
    alu_c     = 1'b0;
    upd_flags = 1'b1;
    upd_res   = 1'b1;
    wr_reg    = 1'b1;
    case (op_q)
      OP_MOV: alu_val = b_q;
      OP_ADD: begin
        alu_val = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_val = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
        if (op_q == OP_CMP) begin
          upd_res = 1'b0;
          wr_reg  = 1'b0;
        end
      end
      OP_AND: alu_val = a_q & b_q;
      OP_MVN: alu_val = ~b_q;
      OP_MUL: begin
        alu_val = acc_q[WIDTH-1:0];
        alu_v   = |acc_q[2*WIDTH-1:WIDTH];
      end
      default: begin
        upd_flags = 1'b0;
        upd_res   = 1'b0;
        wr_reg    = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RDA;
      S_RDA:  state_d = S_RDB;
      S_RDB:  state_d = S_EXEC;
      S_EXEC: if (op_q != OP_MUL || mul_last) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      shift_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WB);
      if (accept) begin
        op_q      <= bus.op;
        rd_q      <= bus.rd;
        rn_q      <= bus.rn;
        rm_q      <= bus.rm;
        use_imm_q <= bus.use_imm;
        imm_q     <= bus.imm;
        shift_q   <= bus.shift;
      end
      if (state_q == S_RDA) a_q <= regs_q[rn_q];
      if (state_q == S_RDB) begin
        b_q   <= b_shift;
        acc_q <= {{WIDTH{1'b0}}, b_shift};
        cnt_q <= '0;
      end
      if (state_q == S_EXEC && op_q == OP_MUL) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_WB) begin
        if (upd_res) result_q <= alu_val;
        if (upd_flags) begin
          z_q <= (alu_val == '0);
          n_q <= alu_val[WIDTH-1];
          v_q <= alu_v;
          c_q <= alu_c;
        end
      end
    end
  end

  // External loads only land in IDLE, so they never race the WB-state writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_IDLE && bus.wr_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end else if (state_q == S_WB && wr_reg) begin
      regs_q[rd_q] <= alu_val;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.Z_out     = z_q;
  assign bus.N_out     = n_q;
  assign bus.V_out     = v_q;
  assign bus.C_out     = c_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq (WIDTH=16, NREGS=8): latency, ALU results, flags,
// shifter, back-to-back starts and mid-operation reset.
module tb_datapath_seq;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;

  datapath_seq_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] flags();
    return {bus.Z_out, bus.N_out, bus.V_out, bus.C_out};
  endfunction

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Issues one op, then checks done latency and busy length; returns in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rn, input logic [2:0] rm, input logic ui,
                        input logic [15:0] imm, input logic [1:0] sh, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.op = op; bus.rd = rd; bus.rn = rn; bus.rm = rm;
    bus.use_imm = ui; bus.imm = imm; bus.shift = sh;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
    end
    if (!bus.done) lat = 99;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_len"}, busy_cnt, exp_lat);
  endtask

  task automatic read_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    run_op({tag, "_rd"}, 3'b000, addr, addr, addr, 1'b0, 16'h0, 2'b00, 4);
    chk(tag, bus.result, exp);
  endtask

  initial begin
    logic [15:0] done_mask;
    total = 0;
    passed = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0;
    bus.use_imm = 1'b0; bus.imm = '0; bus.shift = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_flags", flags(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD 5+3
    do_write(3'd1, 16'd5);
    do_write(3'd2, 16'd3);
    run_op("add", 3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 2'b00, 4);
    chk("add_result", bus.result, 16'd8);
    chk("add_flags", flags(), 4'b0000);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    read_reg("r3_after_add", 3'd3, 16'd8);

    // Signed overflow into the sign bit, then self-subtract
    do_write(3'd1, 16'h7FFF);
    run_op("add_ovf", 3'b001, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0001, 2'b00, 4);
    chk("add_ovf_result", bus.result, 16'h8000);
    chk("add_ovf_flags", flags(), 4'b0110);
    run_op("sub_self", 3'b010, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0, 2'b00, 4);
    chk("sub_self_result", bus.result, 16'h0000);
    chk("sub_self_flags", flags(), 4'b1001);

    // CMP 3 vs 5: flags only
    run_op("cmp", 3'b011, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0005, 2'b00, 4);
    chk("cmp_result_kept", bus.result, 16'h0000);
    chk("cmp_flags", flags(), 4'b0100);
    read_reg("r3_after_cmp", 3'd3, 16'd8);

    // Multiplier
    do_write(3'd6, 16'h0100);
    do_write(3'd7, 16'h1234);
    run_op("mul_big", 3'b110, 3'd7, 3'd6, 3'd6, 1'b0, 16'h0, 2'b00, 19);
    chk("mul_big_result", bus.result, 16'h0000);
    chk("mul_big_flags", flags(), 4'b1010);
    read_reg("r7_after_mul", 3'd7, 16'h0000);
    do_write(3'd1, 16'd7);
    do_write(3'd2, 16'd6);
    run_op("mul_small", 3'b110, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0, 2'b00, 19);
    chk("mul_small_result", bus.result, 16'd42);
    chk("mul_small_flags", flags(), 4'b0000);

    // Shifter on immediate 0x8002
    run_op("asr", 3'b000, 3'd4, 3'd0, 3'd0, 1'b1, 16'h8002, 2'b11, 4);
    chk("asr_result", bus.result, 16'hC001);
    chk("asr_flags", flags(), 4'b0100);
    run_op("lsr", 3'b000, 3'd4, 3'd0, 3'd0, 1'b1, 16'h8002, 2'b10, 4);
    chk("lsr_result", bus.result, 16'h4001);
    chk("lsr_flags", flags(), 4'b0000);
    run_op("lsl", 3'b000, 3'd4, 3'd0, 3'd0, 1'b1, 16'h8002, 2'b01, 4);
    chk("lsl_result", bus.result, 16'h0004);

    // AND and MVN
    do_write(3'd3, 16'h0F0F);
    run_op("and", 3'b100, 3'd4, 3'd3, 3'd0, 1'b1, 16'h00FF, 2'b00, 4);
    chk("and_result", bus.result, 16'h000F);
    run_op("mvn", 3'b101, 3'd4, 3'd0, 3'd3, 1'b0, 16'h0, 2'b00, 4);
    chk("mvn_result", bus.result, 16'hF0F0);
    chk("mvn_flags", flags(), 4'b0100);

    // Reserved op: no write, result/flags kept
    run_op("rsv", 3'b111, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0, 2'b00, 4);
    chk("rsv_result_kept", bus.result, 16'hF0F0);
    chk("rsv_flags_kept", flags(), 4'b0100);
    read_reg("r4_after_rsv", 3'd4, 16'hF0F0);

    // start held high: R1 += R2 three times, accepted at edges 1, 6, 11
    @(negedge clk);
    bus.op = 3'b001; bus.rd = 3'd1; bus.rn = 3'd1; bus.rm = 3'd2;
    bus.use_imm = 1'b0; bus.shift = 2'b00;
    bus.start = 1'b1;
    done_mask = '0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      done_mask[e] = bus.done;
    end
    bus.start = 1'b0;
    chk("b2b_done_mask", done_mask, 16'h8420);
    chk("b2b_result", bus.result, 16'd25);
    @(posedge clk); #1;
    chk("b2b_no_extra", bus.busy, 0);
    read_reg("r1_after_b2b", 3'd1, 16'd25);

    // Reset asserted during EXEC
    @(negedge clk);
    bus.op = 3'b001; bus.rd = 3'd5; bus.rn = 3'd1; bus.rm = 3'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_in_exec_state", bus.state_dbg, 3'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_result", bus.result, 0);
    chk("rst_async_flags", flags(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", bus.done, 0);
    read_reg("r5_after_rst", 3'd5, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
Parametrised, self-sequencing successor to the single-cycle-controlled datapath. It holds an NREGS x WIDTH register file, operand latches A/B, a barrel-lite shifter on B, an ALU with an iterative shift-add multiplier, a result register and a Z/N/V/C status register. An internal FSM replaces the external loada/loadb/loadc/write strobing and is driven by a start/busy/done handshake. It sits under the CPU control FSM, which issues one operation per handshake.

Parameters:
WIDTH, 16, datapath/register width in bits (>=4)
NREGS, 8, number of general registers (power of 2, >=2)
AW, $clog2(NREGS), register address width (derived, do not override)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request an operation; sampled only in IDLE
op  in  3  000 MOV, 001 ADD, 010 SUB, 011 CMP, 100 AND, 101 MVN, 110 MUL, 111 reserved
rd  in  AW  destination register
rn  in  AW  A-operand register
rm  in  AW  B-operand register (ignored when use_imm=1)
use_imm  in  1  1: B operand = imm instead of R[rm]
imm  in  WIDTH  sign-extended immediate supplied by the decoder
shift  in  2  applied to B operand: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
wr_en  in  1  external register load (IDLE only)
wr_addr  in  AW  external load address
wr_data  in  WIDTH  external load data
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the operation completes
result  out  WIDTH  result register (datapath_out equivalent)
Z_out, N_out, V_out, C_out  out  1 each  status flags

Behaviour:
- Reset (async, reset_n=0): state IDLE; all registers, A, B, result and flags = 0; busy=0; done=0. Asserting reset mid-operation aborts the operation with no register write.
- start accepted on an edge where state=IDLE and start=1. op, rd, rn, rm, use_imm, imm and shift are latched on that edge. start while busy is ignored and not queued.
- FSM: IDLE -> RDA (A<=R[rn]) -> RDB (B<=shift(use_imm?imm:R[rm])) -> EXEC -> WB -> IDLE.
- EXEC is one cycle for all ops except MUL. MUL stays in EXEC for WIDTH cycles, one shift-add step per cycle using a 2*WIDTH accumulator.
- WB edge: result and flags are updated, R[rd] is written (except CMP and reserved), and state returns to IDLE. done=1 for exactly the following cycle, which is also the first IDLE cycle. A new start may be accepted in that same cycle.
- Latency from the accepting edge k: done is high in the cycle after edge k+4 for non-MUL ops and after edge k+3+WIDTH for MUL. busy is high for cycles k+1 through the WB edge.
- Arithmetic is modulo 2^WIDTH:
  - MOV: result=B.
  - ADD: A+B. C=carry-out; V=signed overflow.
  - SUB/CMP: A-B. C=no-borrow (A>=B unsigned); V=signed overflow. CMP writes flags only; result and registers are unchanged.
  - AND: A&B.
  - MVN: ~B.
  - MUL: unsigned; low WIDTH bits written. V=1 iff high WIDTH bits are nonzero.
- Flags for MOV, AND, MVN, MUL: C=0. V=0, except MUL as above. Z=(result==0); N=result[WIDTH-1].
- Reserved op: full sequence runs and done pulses; no register write; result and flags unchanged.
- Shift: LSL1 shifts in 0. LSR1 shifts in 0. ASR1 replicates the MSB. The shift is applied after immediate selection.
- External write: wr_en in IDLE writes wr_data to R[wr_addr] on the edge. It is ignored while busy.
- If wr_en and start coincide in IDLE, the write takes effect and the operation reads the new value in RDA/RDB.
- rd may equal rn or rm; operands are already latched, so the writeback does not disturb the current op.

Test Plan:
1. Reset, then load R1=5 and R2=3 externally; ADD rd=3 rn=1 rm=2 -> done exactly 4 cycles after the accepting edge; R3=8, result=8, Z=N=V=C=0, busy high for 4 cycles.
2. WIDTH=16: R1=0x7FFF, imm=1, use_imm ADD -> result 0x8000, N=1, V=1, C=0; then SUB R1-R1 -> 0, Z=1, C=1.
3. CMP R2=3 vs imm=5 -> N=1, C=0, Z=0; R[rd] and result unchanged from prior values.
4. MUL 0x0100*0x0100 (WIDTH=16) -> done at k+19; R[rd]=0x0000, Z=1, V=1. MUL 7*6 -> 42, V=0.
5. Shift=11 on B=0x8002 with MOV -> 0xC001, N=1. Shift=10 on the same value -> 0x4001.
6. start held high continuously -> ops complete back-to-back, a new op accepted in each done cycle, no extra starts queued. reset_n pulsed low in EXEC -> outputs 0 immediately and no write to rd.
